// File: rtl/wb_mem_arbiter_pkg.sv
// Shared definitions for the Wishbone memory arbiter family: FSM state encodings,
// grant encodings, default timing parameters and counter widths.
package wb_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUS   = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_e;

   localparam int DEF_TIMEOUT = 1024;
   localparam int DEF_GAP     = 2;
   localparam int WD_W        = 16;
   localparam int GAP_W       = 8;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_M0   = 2'b01;
   localparam logic [1:0] GNT_M1   = 2'b10;

   // last_grant encoding: the index of the master served most recently
   localparam logic LAST_M1 = 1'b1;

   function automatic logic [GAP_W-1:0] gap_sat_inc(input logic [GAP_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/wb_rr_sel.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// master that was not served last.
module wb_rr_sel
   import wb_mem_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] pick_o
);

   always_comb begin
      pick_o = req_i;
      if (req_i == 2'b11) begin
         pick_o = (last_grant_i == LAST_M1) ? GNT_M0 : GNT_M1;
      end
   end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of the single memory slave: round-robin,
// one transfer per grant, registered response pulses, drain gap and watchdog.
module wb_mem_arbiter
   import wb_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int GAP     = DEF_GAP
) (
   input  logic        CLK100MHZ,
   input  logic        rst,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_idata,
   input  logic [3:0]  m0_sel,
   input  logic        m0_we,
   input  logic        m0_cyc,
   input  logic        m0_stb,
   output logic [31:0] m0_odata,
   output logic        m0_ack,
   output logic        m0_err,
   output logic        m0_rty,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_idata,
   input  logic [3:0]  m1_sel,
   input  logic        m1_we,
   input  logic        m1_cyc,
   input  logic        m1_stb,
   output logic [31:0] m1_odata,
   output logic        m1_ack,
   output logic        m1_err,
   output logic        m1_rty,
   output logic [31:0] s_addr,
   output logic [31:0] s_idata,
   output logic [3:0]  s_sel,
   output logic        s_we,
   output logic        s_cyc,
   output logic        s_stb,
   input  logic [31:0] s_odata,
   input  logic        s_ack,
   input  logic        s_err,
   input  logic        s_rty,
   output logic [1:0]  gnt,
   output logic        busy
);

   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_MIN = GAP_W'(GAP);

   arb_state_e        state_q;
   logic [1:0]        gnt_q;
   logic              last_q;
   logic [WD_W-1:0]   wd_q;
   logic [GAP_W-1:0]  gap_q;
   logic [1:0]        ack_q, err_q, rty_q;
   logic [31:0]       m0_odata_q, m1_odata_q;

   logic [1:0]        req;
   logic [1:0]        pick;
   logic              slv_resp;
   logic              gnt_req;
   logic              bus_done;

   assign req      = {m1_cyc & m1_stb, m0_cyc & m0_stb};
   assign slv_resp = s_ack | s_err | s_rty;
   assign gnt_req  = |(req & gnt_q);
   assign bus_done = slv_resp | (wd_q == WD_LAST) | ~gnt_req;

   wb_rr_sel u_rr_sel (
      .req_i        (req),
      .last_grant_i (last_q),
      .pick_o       (pick)
   );

   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= GNT_NONE;
         last_q     <= LAST_M1;
         wd_q       <= '0;
         gap_q      <= '0;
         ack_q      <= '0;
         err_q      <= '0;
         rty_q      <= '0;
         m0_odata_q <= '0;
         m1_odata_q <= '0;
      end else begin
         ack_q <= '0;
         err_q <= '0;
         rty_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (|req) begin
                  gnt_q   <= pick;
                  last_q  <= pick[1];
                  wd_q    <= '0;
                  state_q <= ST_BUS;
               end
            end
            ST_BUS: begin
               // ack beats err beats rty beats watchdog; a same-cycle abort still delivers the response
               if (s_ack) begin
                  ack_q <= gnt_q;
                  if (gnt_q[0]) m0_odata_q <= s_odata;
                  if (gnt_q[1]) m1_odata_q <= s_odata;
               end else if (s_err) begin
                  err_q <= gnt_q;
               end else if (s_rty) begin
                  rty_q <= gnt_q;
               end else if (wd_q == WD_LAST) begin
                  err_q <= gnt_q;
               end
               if (bus_done) begin
                  gnt_q   <= GNT_NONE;
                  gap_q   <= '0;
                  state_q <= ST_DRAIN;
               end else begin
                  wd_q <= wd_q + 1'b1;
               end
            end
            ST_DRAIN: begin
               if ((gap_q >= GAP_MIN) && !slv_resp) begin
                  state_q <= ST_IDLE;
               end else begin
                  gap_q <= gap_sat_inc(gap_q);
               end
            end
            default: begin
               gnt_q   <= GNT_NONE;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // slave-side request is driven only while a grant is held
   always_comb begin
      s_addr  = '0;
      s_idata = '0;
      s_sel   = '0;
      s_we    = 1'b0;
      if (gnt_q[0]) begin
         s_addr  = m0_addr;
         s_idata = m0_idata;
         s_sel   = m0_sel;
         s_we    = m0_we;
      end else if (gnt_q[1]) begin
         s_addr  = m1_addr;
         s_idata = m1_idata;
         s_sel   = m1_sel;
         s_we    = m1_we;
      end
   end

   assign s_cyc    = (state_q == ST_BUS);
   assign s_stb    = (state_q == ST_BUS);
   assign gnt      = gnt_q;
   assign busy     = (state_q != ST_IDLE);
   assign m0_ack   = ack_q[0];
   assign m0_err   = err_q[0];
   assign m0_rty   = rty_q[0];
   assign m1_ack   = ack_q[1];
   assign m1_err   = err_q[1];
   assign m1_rty   = rty_q[1];
   assign m0_odata = m0_odata_q;
   assign m1_odata = m1_odata_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with a small memory slave model that acks
// two cycles after it first sees s_stb, or never when noack is set.
module tb_wb_mem_arbiter;

   logic        CLK100MHZ = 1'b0;
   logic        rst;
   logic [31:0] m0_addr, m0_idata, m1_addr, m1_idata;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
   logic [31:0] m0_odata, m1_odata;
   logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
   logic [31:0] s_addr, s_idata, s_odata;
   logic [3:0]  s_sel;
   logic        s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
   logic [1:0]  gnt;
   logic        busy;

   logic        noack;
   logic [31:0] mem [0:15];
   logic [1:0]  scnt;

   int checks = 0;
   int errors = 0;

   always #5 CLK100MHZ = ~CLK100MHZ;

   wb_mem_arbiter #(.TIMEOUT(16), .GAP(2)) dut (
      .CLK100MHZ (CLK100MHZ), .rst (rst),
      .m0_addr (m0_addr), .m0_idata (m0_idata), .m0_sel (m0_sel), .m0_we (m0_we),
      .m0_cyc (m0_cyc), .m0_stb (m0_stb), .m0_odata (m0_odata),
      .m0_ack (m0_ack), .m0_err (m0_err), .m0_rty (m0_rty),
      .m1_addr (m1_addr), .m1_idata (m1_idata), .m1_sel (m1_sel), .m1_we (m1_we),
      .m1_cyc (m1_cyc), .m1_stb (m1_stb), .m1_odata (m1_odata),
      .m1_ack (m1_ack), .m1_err (m1_err), .m1_rty (m1_rty),
      .s_addr (s_addr), .s_idata (s_idata), .s_sel (s_sel), .s_we (s_we),
      .s_cyc (s_cyc), .s_stb (s_stb), .s_odata (s_odata),
      .s_ack (s_ack), .s_err (s_err), .s_rty (s_rty),
      .gnt (gnt), .busy (busy)
   );

   // memory slave model; the read word is the pre-write contents
   always @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         s_ack   <= 1'b0;
         scnt    <= '0;
         s_odata <= '0;
         for (int i = 0; i < 16; i++) mem[i] <= '0;
         mem[4]  <= 32'hDEADBEEF;
         mem[8]  <= 32'h11223344;
      end else if (!s_stb) begin
         s_ack <= 1'b0;
         scnt  <= '0;
      end else if (s_ack) begin
         s_ack <= 1'b0;
      end else if (!noack) begin
         if (scnt == 2'd1) begin
            s_ack   <= 1'b1;
            s_odata <= mem[s_addr[5:2]];
            if (s_we) begin
               for (int b = 0; b < 4; b++)
                  if (s_sel[b]) mem[s_addr[5:2]][8*b +: 8] <= s_idata[8*b +: 8];
            end
         end else begin
            scnt <= scnt + 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK100MHZ);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      chk("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   task automatic drive(input int m, input logic on, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] sel, input logic we);
      if (m == 0) begin
         m0_cyc = on; m0_stb = on; m0_addr = addr; m0_idata = data; m0_sel = sel; m0_we = we;
      end else begin
         m1_cyc = on; m1_stb = on; m1_addr = addr; m1_idata = data; m1_sel = sel; m1_we = we;
      end
   endtask

   task automatic xfer(input int m, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] sel, input logic we,
                       output int lat, output logic got_ack, output logic other_resp);
      logic done;
      lat = 0; got_ack = 1'b0; other_resp = 1'b0; done = 1'b0;
      drive(m, 1'b1, addr, data, sel, we);
      while (!done && lat < 40) begin
         tick();
         lat++;
         if (m == 0) begin
            done = m0_ack | m0_err;
            got_ack = m0_ack;
            other_resp = other_resp | m1_ack | m1_err | m1_rty;
         end else begin
            done = m1_ack | m1_err;
            got_ack = m1_ack;
            other_resp = other_resp | m0_ack | m0_err | m0_rty;
         end
      end
      drive(m, 1'b0, addr, data, sel, we);
      wait_idle();
   endtask

   initial begin
      int lat, n, ngr, low, minlow, both;
      int gtick [4];
      logic [1:0] gseq [4];
      logic [1:0] prev;
      logic got, other, seen;

      rst = 1'b1; noack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      tick(); tick();
      chk("rst_gnt", {30'd0, gnt}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_stb", {31'd0, s_stb}, 32'd0);
      chk("rst_odata", m0_odata, 32'd0);
      rst = 1'b0;
      tick();

      // single m0 read, cycle by cycle
      drive(0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
      tick();
      chk("rd_gnt", {30'd0, gnt}, 32'd1);
      chk("rd_stb", {31'd0, s_stb}, 32'd1);
      chk("rd_saddr", s_addr, 32'h10);
      tick();
      chk("rd_ack_early1", {31'd0, m0_ack}, 32'd0);
      tick();
      chk("rd_ack_early2", {31'd0, m0_ack}, 32'd0);
      tick();
      chk("rd_ack", {31'd0, m0_ack}, 32'd1);
      chk("rd_odata", m0_odata, 32'hDEADBEEF);
      chk("rd_gnt_drop", {30'd0, gnt}, 32'd0);
      chk("rd_stb_drop", {31'd0, s_stb}, 32'd0);
      chk("rd_m1_silent", {29'd0, m1_ack, m1_err, m1_rty}, 32'd0);
      drive(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
      tick();
      chk("rd_ack_pulse", {31'd0, m0_ack}, 32'd0);
      wait_idle();

      // m1 byte-lane write then readback
      xfer(1, 32'h20, 32'h0000AB00, 4'b0010, 1'b1, lat, got, other);
      chk("wr_ack", {31'd0, got}, 32'd1);
      chk("wr_latency", lat, 32'd4);
      xfer(1, 32'h20, 32'h0, 4'hF, 1'b0, lat, got, other);
      chk("rb_ack", {31'd0, got}, 32'd1);
      chk("rb_data", m1_odata, 32'h1122AB44);
      chk("rb_m0_silent", {31'd0, other}, 32'd0);

      // both masters held: grants alternate with a drain gap between them
      drive(0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
      drive(1, 1'b1, 32'h20, 32'h0, 4'hF, 1'b0);
      prev = 2'b00; ngr = 0; low = 0; minlow = 99; both = 0;
      for (int t = 0; t < 60 && ngr < 4; t++) begin
         tick();
         if (m0_ack && m1_ack) both++;
         if (gnt != 2'b00 && prev == 2'b00) begin
            if (ngr > 0 && low < minlow) minlow = low;
            gseq[ngr] = gnt;
            gtick[ngr] = t;
            ngr++;
            low = 0;
         end else if (!s_stb) begin
            low++;
         end
         prev = gnt;
      end
      chk("rr_count", ngr, 32'd4);
      chk("rr_g0", {30'd0, gseq[0]}, 32'd1);
      chk("rr_g1", {30'd0, gseq[1]}, 32'd2);
      chk("rr_g2", {30'd0, gseq[2]}, 32'd1);
      chk("rr_g3", {30'd0, gseq[3]}, 32'd2);
      chk("rr_interval", gtick[1] - gtick[0], 32'd7);
      chk("rr_gap_ok", {31'd0, minlow >= 2}, 32'd1);
      chk("rr_no_dual_ack", both, 32'd0);
      drive(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
      drive(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
      tick();
      wait_idle();

      // watchdog on a silent slave
      noack = 1'b1;
      drive(1, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
      tick();
      chk("wd_gnt", {30'd0, gnt}, 32'd2);
      n = 0;
      while (!m1_err && n < 40) begin
         tick();
         n++;
      end
      chk("wd_err_delay", n, 32'd16);
      chk("wd_stb_drop", {31'd0, s_stb}, 32'd0);
      chk("wd_no_ack", {31'd0, m1_ack}, 32'd0);
      drive(1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
      wait_idle();
      noack = 1'b0;
      xfer(1, 32'h10, 32'h0, 4'hF, 1'b0, lat, got, other);
      chk("wd_recover_ack", {31'd0, got}, 32'd1);
      chk("wd_recover_data", m1_odata, 32'hDEADBEEF);

      // m0 abort one cycle after grant
      drive(0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
      tick();
      chk("ab_gnt", {30'd0, gnt}, 32'd1);
      m0_cyc = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 8; t++) begin
         tick();
         seen = seen | m0_ack | m0_err | m0_rty;
         if (t == 0) begin
            chk("ab_gnt_drop", {30'd0, gnt}, 32'd0);
            chk("ab_busy_drain", {31'd0, busy}, 32'd1);
         end
      end
      chk("ab_no_resp", {31'd0, seen}, 32'd0);
      chk("ab_idle", {31'd0, busy}, 32'd0);
      m0_stb = 1'b0;

      // asynchronous reset in the middle of a transfer
      drive(1, 1'b1, 32'h20, 32'h0, 4'hF, 1'b0);
      tick();
      chk("ar_gnt", {30'd0, gnt}, 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("ar_gnt_rst", {30'd0, gnt}, 32'd0);
      chk("ar_stb_rst", {31'd0, s_stb}, 32'd0);
      chk("ar_busy_rst", {31'd0, busy}, 32'd0);
      chk("ar_m1_odata_rst", m1_odata, 32'd0);
      chk("ar_m0_odata_rst", m0_odata, 32'd0);
      drive(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
      tick();
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
